// File: rtl/prod_dot_acc.sv
// rtl/prod_dot_acc.sv - accumulates a run of unsigned products into a wrap/saturate dot-product sum
module prod_dot_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              sat_en,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sat_q, sat_d;
  logic [ACC_W:0]     sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    // one extra bit so the carry out of the accumulator is visible
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          sat_d   = sat_en;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (prod_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
            acc_d = sat_q ? '1 : sum[ACC_W-1:0];
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          if (cnt_d == len_q) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (acc_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

  assign prod_ready = (state_q == S_ACC);
  assign acc_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_prod_dot_acc.sv
// tb/tb_prod_dot_acc.sv - vector-table bench driving 24-bit and 18-bit accumulators side by side
module tb_prod_dot_acc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sat_en, prod_valid, acc_ready;
  logic [7:0]  len;
  logic [15:0] prod;

  logic        pr_a, av_a, ovf_a, busy_a;
  logic [23:0] acc_a;
  logic        pr_b, av_b, ovf_b, busy_b;
  logic [17:0] acc_b;

  int checks = 0;
  int errors = 0;

  prod_dot_acc #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .sat_en(sat_en),
    .prod_valid(prod_valid), .prod_ready(pr_a), .prod(prod),
    .acc_valid(av_a), .acc_ready(acc_ready), .acc_out(acc_a),
    .ovf(ovf_a), .busy(busy_a)
  );

  prod_dot_acc #(.PROD_W(16), .ACC_W(18), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .sat_en(sat_en),
    .prod_valid(prod_valid), .prod_ready(pr_b), .prod(prod),
    .acc_valid(av_b), .acc_ready(acc_ready), .acc_out(acc_b),
    .ovf(ovf_b), .busy(busy_b)
  );

  typedef struct {
    int unsigned len;
    bit          sat;
    int unsigned base;
    int unsigned step;
    int unsigned last;
    int unsigned gap;
    int unsigned hold;
    int unsigned exp24;
    bit          ovf24;
    int unsigned exp18;
    bit          ovf18;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready_a"}, pr_a, 0);
    check({tag, "_ready_b"}, pr_b, 0);
    check({tag, "_valid_a"}, av_a, 0);
    check({tag, "_valid_b"}, av_b, 0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_acc_a"}, acc_a, 0);
    check({tag, "_acc_b"}, acc_b, 0);
    check({tag, "_ovf_a"}, ovf_a, 0);
    check({tag, "_ovf_b"}, ovf_b, 0);
  endtask

  task automatic do_start(input int unsigned l, input bit s);
    @(negedge clk);
    start = 1'b1; len = l[7:0]; sat_en = s; prod_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; len = 8'($urandom); sat_en = 1'($urandom);
    check("start_busy_a", busy_a, 1);
    check("start_busy_b", busy_b, 1);
    check("start_ready", pr_a, 32'(l != 0));
    check("start_valid", av_a, 32'(l == 0));
  endtask

  task automatic feed(input logic [15:0] p);
    prod_valid = 1'b1; prod = p;
    @(negedge clk);
    prod_valid = 1'b0; prod = 16'($urandom);
  endtask

  task automatic idle_cycles(input int unsigned n);
    prod_valid = 1'b0;
    for (int k = 0; k < int'(n); k++) begin
      @(negedge clk);
      check("gap_ready", pr_a, 1);
      check("gap_no_valid", av_a, 0);
    end
  endtask

  task automatic expect_result(input string tag, input int unsigned e24, input bit o24,
                               input int unsigned e18, input bit o18, input int unsigned hold);
    check({tag, "_valid_a"}, av_a, 1);
    check({tag, "_valid_b"}, av_b, 1);
    check({tag, "_hold_ready"}, pr_a, 0);
    check({tag, "_acc_a"}, acc_a, e24);
    check({tag, "_ovf_a"}, ovf_a, o24);
    check({tag, "_acc_b"}, acc_b, e18);
    check({tag, "_ovf_b"}, ovf_b, o18);
    for (int h = 0; h < int'(hold); h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, av_a, 1);
      check({tag, "_hold_acc_a"}, acc_a, e24);
      check({tag, "_hold_acc_b"}, acc_b, e18);
      check({tag, "_hold_ovf_b"}, ovf_b, o18);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check({tag, "_post_valid"}, av_a, 0);
    check({tag, "_post_busy"}, busy_a, 0);
    check({tag, "_post_acc_a"}, acc_a, e24);
    check({tag, "_post_ovf_b"}, ovf_b, o18);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    do_start(v.len, v.sat);
    for (int i = 0; i < int'(v.len); i++) begin
      if (i > 0) idle_cycles(v.gap);
      feed((i == int'(v.len) - 1) ? v.last[15:0] : 16'(v.base + 32'(i) * v.step));
      if (i < int'(v.len) - 1) begin
        check({tag, "_early_valid"}, av_a, 0);
        check({tag, "_mid_ready"}, pr_a, 1);
      end
    end
    expect_result(tag, v.exp24, v.ovf24, v.exp18, v.ovf18, v.hold);
  endtask

  initial begin
    vec_t v;
    //         len sat base   step last   gap hold exp24   o24 exp18   o18
    vecs[0] = '{4, 0, 65025, 0,   65025, 0,  0,   260100, 0,  260100, 0};
    vecs[1] = '{3, 0, 100,   100, 300,   2,  5,   600,    0,  600,    0};
    vecs[2] = '{5, 1, 65025, 0,   65025, 0,  1,   325125, 0,  262143, 1};
    vecs[3] = '{5, 0, 65025, 0,   65025, 0,  0,   325125, 0,  62981,  1};
    vecs[4] = '{0, 0, 0,     0,   0,     0,  2,   0,      0,  0,      0};
    vecs[5] = '{5, 0, 65535, 0,   3,     0,  0,   262143, 0,  262143, 0};
    vecs[6] = '{5, 0, 65535, 0,   4,     0,  0,   262144, 0,  0,      1};
    vecs[7] = '{5, 1, 65535, 0,   4,     0,  0,   262144, 0,  262143, 1};
    vecs[8] = '{8, 1, 65535, 0,   65535, 1,  0,   524280, 0,  262143, 1};
    vecs[9] = '{8, 0, 65535, 0,   65535, 0,  0,   524280, 0,  262136, 1};

    rst = 1'b1; start = 1'b1; len = 8'd3; sat_en = 1'b0;
    prod_valid = 1'b1; prod = 16'd77; acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0; start = 1'b0; prod_valid = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    for (int n = 0; n < 10; n++) begin
      run_vec($sformatf("vec%0d", n), vecs[n]);
    end

    // abort mid-run; the product presented with reset must be dropped
    do_start(6, 0);
    feed(16'd1000);
    feed(16'd1000);
    feed(16'd1000);
    check("midrun_acc", acc_a, 3000);
    rst = 1'b1; prod_valid = 1'b1; prod = 16'd500;
    @(negedge clk);
    rst = 1'b0; prod_valid = 1'b0;
    check_idle_zero("midrun_rst");
    v = '{2, 0, 10, 10, 20, 0, 0, 30, 0, 30, 0};
    run_vec("after_rst", v);

    // start while busy must not disturb the run
    do_start(3, 0);
    feed(16'd7);
    start = 1'b1; len = 8'd1; prod_valid = 1'b1; prod = 16'd8;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b0;
    check("acc_start_busy", busy_a, 1);
    check("acc_start_valid", av_a, 0);
    check("acc_start_sum", acc_a, 15);
    feed(16'd9);
    check("hold_valid", av_a, 1);
    check("hold_sum", acc_a, 24);
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("hold_start_valid", av_a, 1);
    check("hold_start_sum", acc_a, 24);
    start = 1'b1; len = 8'd2; acc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; acc_ready = 1'b0;
    check("exit_start_busy", busy_a, 0);
    check("exit_start_valid", av_a, 0);
    check("exit_start_acc", acc_a, 24);
    do_start(1, 0);
    feed(16'd5);
    expect_result("restart", 5, 0, 5, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_dot_acc.md
Name: prod_dot_acc

Overview:
- Downstream consumer of the 8x8 approximate multiplier's 16-bit product (prod8).
- Accumulates a run of `len` products into a dot-product sum. Products arrive through a valid/ready handshake.
- Holds the final sum under an output valid/ready handshake.
- Used to evaluate approximate-multiplier accuracy on FPGA against the exact dot product computed in software.

Parameters:
- PROD_W, 16, width of incoming product (matches prod8).
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the run-length input.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE.
- len  input  LEN_W  number of products in the run; sampled with start.
- sat_en  input  1  1 = saturate on overflow, 0 = wrap; sampled with start.
- prod_valid  input  1  upstream product valid.
- prod_ready  output  1  block accepts a product this cycle.
- prod  input  PROD_W  unsigned product from the multiplier.
- acc_valid  output  1  result available.
- acc_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  accumulated sum.
- ovf  output  1  sticky overflow flag for the current run.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - acc_out=0, ovf=0, acc_valid=0, prod_ready=0, busy=0.
  - Count cleared; latched len/sat_en cleared.
  - Reset wins over every other input in the same cycle.
- States: IDLE, ACC, HOLD.
- IDLE:
  - prod_ready=0, acc_valid=0.
  - On start:
    - Latch len and sat_en.
    - Clear the accumulator, count and ovf.
    - If len==0, go to HOLD with acc_out=0.
    - Otherwise go to ACC.
- ACC:
  - prod_ready=1, busy=1.
  - A handshake is prod_valid & prod_ready in the same cycle.
  - On a handshake: sum = acc + zero-extended prod, computed at ACC_W+1 bits, and count increments.
  - If sum > 2^ACC_W-1, set ovf (sticky), then:
    - sat_en=1: acc = all ones.
    - sat_en=0: acc = sum mod 2^ACC_W.
  - Once saturated, further products leave acc at all ones.
  - The handshake where count reaches the latched len moves the state to HOLD on the same edge.
  - No handshake (prod_valid=0): state and accumulator unchanged.
- HOLD:
  - prod_ready=0, acc_valid=1.
  - acc_out and ovf stay stable until acc_ready=1.
  - On acc_ready=1, go to IDLE; acc_valid drops next cycle.
  - acc_out and ovf keep their values in IDLE until the next start.
- Latency:
  - acc_valid rises on the cycle after the final product handshake.
  - Throughput is one product per cycle with no bubbles.
- start outside IDLE is ignored. This includes start in the same cycle as the HOLD->IDLE transition: a new run needs a start in a later cycle.
- prod is sampled only on a handshake; its value at other times is don't-care.
- Reset mid-run aborts the run. No result is produced, and an in-flight product presented that cycle is dropped.
- Arithmetic is unsigned only. No rounding or error correction; products are accumulated exactly as delivered.

Test Plan:
- len=4, sat_en=0, prod=65025 (255*255) on 4 back-to-back cycles -> acc_valid one cycle after the 4th handshake, acc_out=260100 (0x3F804), ovf=0.
- len=3, products 100, 200, 300 with prod_valid low for 2 cycles between each -> prod_ready stays 1 throughout, acc_out=600; acc_valid held with acc_ready low for 5 cycles, acc_out stable, IDLE one cycle after acc_ready.
- ACC_W=18, len=5, prod=65025 each:
  - sat_en=1 -> acc_out=262143, ovf=1.
  - sat_en=0 -> acc_out=62981 (325125 mod 262144), ovf=1.
- len=0 start -> HOLD next cycle with acc_out=0, ovf=0; no product accepted.
- Reset mid-run: start len=6, accept 3 products, assert rst -> next cycle IDLE, all outputs 0. A following len=2 run of 10 and 20 -> acc_out=30.
- Start during ACC and during HOLD is ignored (sum unaffected). Start while in HOLD with acc_ready=1 -> no new run; a start 1 cycle later begins one.
